seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Time-multiplexed scan controller for the 8-digit 7-segment display on the board.
- Holds a 32-bit display word and steps through its digits one at a time, presenting one hex nibble per slot to the nibble-to-segment decoder directly downstream.
- Registers the decoder's 8-bit segment pattern together with a one-hot digit select, and inserts a blanking gap between digits to prevent ghosting.
- Display word updates are double-buffered and take effect only at frame boundaries.

Parameters:
- NDIG, 8, number of digits scanned (1..8); digit i shows data bits [4i+3:4i].
- SLOT_CYCLES, 1024, clock cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 16, cycles at the start of each slot with all outputs dark (>= 1).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  single-cycle strobe; capture data_in into pending buffer
- data_in  input  32  new display word
- nibble  output  4  current digit's nibble, to decoder input
- seg_in  input  8  decoder output for nibble (bit7=a .. bit1=g, bit0=dp; 1=lit)
- seg_out  output  8  registered segments to pins, 1=lit
- dig_sel  output  NDIG  registered one-hot digit enable, 1=on
- frame_start  output  1  one-cycle pulse when pending word becomes active
- busy  output  1  high while a loaded word waits to be applied

Behaviour:
- Reset (async assert, sync release): pending=0, active=0, digit index=0, slot counter=0, state=BLANK.
- Reset output values: seg_out=0, dig_sel=0, frame_start=0, busy=0.
- State machine per slot:
  - BLANK: counter runs 0..BLANK_CYCLES-1; seg_out and dig_sel registered to 0.
  - ON: counter runs BLANK_CYCLES..SLOT_CYCLES-1; each cycle seg_out<=seg_in and dig_sel<=one-hot(index).
  - At counter=SLOT_CYCLES-1: counter<=0, state<=BLANK, index<=index+1, wrapping NDIG-1 -> 0.
- Nibble path: nibble = active[4*index+3 : 4*index], combinational from registered state. The decoder is combinational, so seg_in is valid in the same cycle. seg_out/dig_sel therefore lag index/state by exactly one cycle, and segment and select always change on the same edge.
- Frame boundary is the cycle where the index wraps to 0.
  - If busy=1 at the boundary: active<=pending, busy<=0, frame_start=1 on the next cycle.
  - If busy=0: no transfer and no pulse.
- Load handling:
  - load=1 sets pending<=data_in and busy<=1. Later loads before the boundary overwrite pending; the last one wins.
  - Load on the boundary cycle itself: the transfer uses the old pending value. The new value is held with busy staying 1 and is applied at the next boundary.
- Display never tears: active changes only at the frame boundary, and that cycle is in the dark BLANK phase.
- Reset mid-slot: outputs go dark immediately (async); scanning restarts at digit 0 in BLANK.
- Digits >= NDIG are never selected. dig_sel never has more than one bit set.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: during ON, digit i is forced dark (seg_out=0, dig_sel bit still driven) when i>0 and all nibbles from digit i up to NDIG-1 are zero. Digit 0 is always shown, so 0x00000000 displays a single "0".
- Not defined: every digit shows its nibble, including leading zeros.
- Suppression is computed from active, and so changes only at frame boundaries.

Test Plan:
- Reset release, no load, NDIG=8, SLOT_CYCLES=32, BLANK_CYCLES=4 -> dig_sel cycles 0x01,0x02..0x80,0x01. Each digit is on for 28 cycles with 4 dark cycles between. seg_out=0xFC (decoder "0") whenever lit.
- load data_in=0x89ABCDEF mid-frame -> busy=1 until next wrap. frame_start pulses once. Digit 0 then shows the decoder pattern for F (0x8E) and digit 7 shows 8 (0xFE). The old word persists until the wrap.
- Two loads in one frame (0x11111111, then 0x22222222) -> only 0x22222222 is ever displayed; exactly one frame_start.
- Load asserted on the boundary cycle with 0x12345678 -> previous pending is applied now. 0x12345678 appears one frame later with a second frame_start.
- Assert reset during ON of digit 5 -> seg_out=0 and dig_sel=0 in the same cycle. After release the first lit digit is 0 after 4 blank cycles; active=0.
- With SEG7_LEADING_ZERO_BLANK_EN, load 0x00000A05 -> digits 0,1,2 lit (0xB6, 0xFC, 0xEE); digits 3..7 dark. Without the macro, digits 3..7 show 0xFC.

Source files
------------

// File: rtl/seg7_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_if
// Brief    : Display-word load port, decoder loop and pin outputs of the
//            7-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_if #(
    parameter int NDIG = 8
);
    logic            load;
    logic [31:0]     data_in;
    logic [3:0]      nibble;
    logic [7:0]      seg_in;
    logic [7:0]      seg_out;
    logic [NDIG-1:0] dig_sel;
    logic            frame_start;
    logic            busy;

    modport master (
        output load, data_in, seg_in,
        input  nibble, seg_out, dig_sel, frame_start, busy
    );

    modport slave (
        input  load, data_in, seg_in,
        output nibble, seg_out, dig_sel, frame_start, busy
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Time-multiplexed 8-digit 7-segment scanner with blanking gap and
//            frame-aligned double-buffered display word.
//            Option macro SEG7_LEADING_ZERO_BLANK_EN darkens leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NDIG         = 8,
    parameter int SLOT_CYCLES  = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  wire logic  clock,
    input  wire logic  reset,
    seg7_scan_if.slave bus
);
    localparam int c_CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int c_IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [31:0]          r_active;
    logic [31:0]          r_pending;
    logic                 r_busy;
    logic                 r_frame_start;
    logic [7:0]           r_seg;
    logic [NDIG-1:0]      r_dig;

    logic                 w_slot_end;
    logic                 w_last_dig;
    logic                 w_boundary;
    logic [NDIG-1:0]      w_onehot;
    logic [c_IDX_W+1:0]   w_bit_ofs;
    logic                 w_suppress;

    assign w_slot_end = (r_cnt == c_CNT_W'(SLOT_CYCLES - 1));
    assign w_last_dig = (r_idx == c_IDX_W'(NDIG - 1));
    assign w_boundary = w_slot_end && w_last_dig;
    assign w_bit_ofs  = {r_idx, 2'b00};

    assign bus.nibble      = r_active[w_bit_ofs +: 4];
    assign bus.seg_out     = r_seg;
    assign bus.dig_sel     = r_dig;
    assign bus.frame_start = r_frame_start;
    assign bus.busy        = r_busy;

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_upper_zero;

    // A digit is a leading zero when it and every more-significant digit are 0.
    always_comb begin
        w_upper_zero = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if ((i >= int'(r_idx)) && (r_active[4*i +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
        w_suppress = (r_idx != '0) && w_upper_zero;
    end
`else
    assign w_suppress = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BLANK: if (r_cnt == c_CNT_W'(BLANK_CYCLES - 1)) w_state_nxt = ST_ON;
            ST_ON:    if (w_slot_end) w_state_nxt = ST_BLANK;
            default:  w_state_nxt = ST_BLANK;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_active      <= '0;
            r_pending     <= '0;
            r_busy        <= 1'b0;
            r_frame_start <= 1'b0;
            r_seg         <= '0;
            r_dig         <= '0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end) begin
                r_idx <= w_last_dig ? '0 : r_idx + 1'b1;
            end

            // The wrap edge lands in BLANK, so swapping the word here never tears.
            r_frame_start <= w_boundary && r_busy;
            if (w_boundary && r_busy) begin
                r_active <= r_pending;
                r_busy   <= 1'b0;
            end
            if (bus.load) begin
                r_pending <= bus.data_in;
                r_busy    <= 1'b1;
            end

            if (r_state == ST_ON) begin
                r_seg <= w_suppress ? 8'h00 : bus.seg_in;
                r_dig <= w_onehot;
            end else begin
                r_seg <= 8'h00;
                r_dig <= '0;
            end
        end
    end
endmodule
`default_nettype wire
